// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite SRAM slave: byte-lane writable memory region with a fixed number of
// wait states per OKAY data phase and a two-cycle ERROR response.
module ahb_lite_sram_slave #(
    parameter int unsigned MEM_BYTES   = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic        HRESP
);

    localparam int unsigned AW    = $clog2(MEM_BYTES);
    localparam int unsigned WORDS = MEM_BYTES / 4;
    localparam logic [3:0]  WS    = 4'(WAIT_STATES);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } state_t;

    state_t        state_reg, state_next;
    logic [3:0]    cnt_reg, cnt_next;
    logic [AW-1:0] addr_reg;
    logic          write_reg;
    logic [1:0]    size_reg;

    logic          accept;
    logic          take;
    logic          in_range;
    logic          size_err;
    logic          req_err;
    logic [31:0]   offset;
    logic [3:0]    byte_en;
    logic [3:0]    lane_we;
    logic [31:0]   rd_word;
    logic [AW-3:0] word_idx;

    // Bursts need no special handling: every beat is decoded on its own.
    logic unused_hburst;
    assign unused_hburst = ^HBURST;

    // Address-phase decode. The subtraction is unsigned, so addresses below the
    // base fail the first term instead of wrapping into the region.
    assign accept   = HSEL & HREADY & HTRANS[1];
    assign offset   = HADDR - BASE_ADDR;
    assign in_range = (HADDR >= BASE_ADDR) && (offset < 32'(MEM_BYTES));
    assign size_err = (HSIZE > 3'd2)
                    || ((HSIZE == 3'd1) && HADDR[0])
                    || ((HSIZE == 3'd2) && (HADDR[1:0] != 2'b00));
    assign req_err  = !in_range || size_err;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= 4'd0;
            addr_reg  <= '0;
            write_reg <= 1'b0;
            size_reg  <= 2'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (take) begin
                addr_reg  <= offset[AW-1:0];
                write_reg <= HWRITE;
                size_reg  <= HSIZE[1:0];
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        take       = 1'b0;
        HREADYOUT  = 1'b1;
        HRESP      = 1'b0;
        HRDATA     = 32'h0;
        case (state_reg)
            ST_IDLE, ST_DATA, ST_ERR2: begin
                if (state_reg == ST_DATA) begin
                    HRDATA = rd_word;
                end
                if (state_reg == ST_ERR2) begin
                    HRESP = 1'b1;
                end
                // A new address phase may overlap the completing data phase.
                if (accept) begin
                    take = 1'b1;
                    if (req_err) begin
                        state_next = ST_ERR1;
                    end else if (WS != 4'd0) begin
                        state_next = ST_WAIT;
                        cnt_next   = WS;
                    end else begin
                        state_next = ST_DATA;
                    end
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_WAIT: begin
                HREADYOUT = 1'b0;
                if (cnt_reg <= 4'd1) begin
                    state_next = ST_DATA;
                    cnt_next   = 4'd0;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            ST_ERR1: begin
                HREADYOUT  = 1'b0;
                HRESP      = 1'b1;
                state_next = ST_ERR2;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Little-endian lane selection from the latched size and low address bits.
    always_comb begin
        byte_en = 4'b1111;
        case (size_reg)
            2'd0:    byte_en = 4'b0001 << addr_reg[1:0];
            2'd1:    byte_en = addr_reg[1] ? 4'b1100 : 4'b0011;
            default: byte_en = 4'b1111;
        endcase
    end

    assign word_idx = addr_reg[AW-1:2];

    // One byte-wide array per lane. Reads are asynchronous on the latched
    // address, so a read directly after a write to the same word sees the
    // bytes committed on the edge that started the read data phase.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_mem [WORDS];

            assign lane_we[gi] = (state_reg == ST_DATA) && write_reg
                               && byte_en[gi] && !HRESET;

            always_ff @(posedge HCLK) begin
                if (lane_we[gi]) begin
                    lane_mem[word_idx] <= HWDATA[8*gi +: 8];
                end
            end

            assign rd_word[8*gi +: 8] = lane_mem[word_idx];
        end
    endgenerate

endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
// Directed bench for ahb_lite_sram_slave: one zero-wait instance and one
// three-wait instance on a shared address/data bus with separate selects.
module tb_ahb_lite_sram_slave;

    localparam logic [1:0] T_IDLE = 2'b00;
    localparam logic [1:0] T_BUSY = 2'b01;
    localparam logic [1:0] T_NSEQ = 2'b10;
    localparam logic [1:0] T_SEQ  = 2'b11;

    logic        hclk;
    logic        hreset;
    logic        hsel0, hsel3;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [31:0] hwdata;
    logic [31:0] rdata0, rdata3;
    logic        rdy0, rdy3;
    logic        resp0, resp3;

    int total = 0;
    int bad   = 0;

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    ahb_lite_sram_slave #(
        .MEM_BYTES(1024), .BASE_ADDR(32'h0), .WAIT_STATES(0)
    ) u_dut0 (
        .HCLK(hclk), .HRESET(hreset), .HSEL(hsel0), .HADDR(haddr),
        .HTRANS(htrans), .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst),
        .HWDATA(hwdata), .HREADY(rdy0), .HRDATA(rdata0),
        .HREADYOUT(rdy0), .HRESP(resp0)
    );

    ahb_lite_sram_slave #(
        .MEM_BYTES(1024), .BASE_ADDR(32'h0), .WAIT_STATES(3)
    ) u_dut3 (
        .HCLK(hclk), .HRESET(hreset), .HSEL(hsel3), .HADDR(haddr),
        .HTRANS(htrans), .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst),
        .HWDATA(hwdata), .HREADY(rdy3), .HRDATA(rdata3),
        .HREADYOUT(rdy3), .HRESP(resp3)
    );

    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    task automatic addr_ph(input logic [1:0] tr, input logic wr,
                           input logic [31:0] a, input logic [2:0] sz);
        htrans = tr;
        hwrite = wr;
        haddr  = a;
        hsize  = sz;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
        $display("check %-14s got %h expected %h", tag, obs, exp);
    endtask

    initial begin
        hreset = 1'b1;
        hsel0  = 1'b0;
        hsel3  = 1'b0;
        hburst = 3'b000;
        hwdata = 32'h0;
        addr_ph(T_IDLE, 1'b0, 32'h0, 3'd2);
        tick();
        tick();
        hreset = 1'b0;
        chk("rst_rdy0", 32'(rdy0), 32'd1);
        chk("rst_resp0", 32'(resp0), 32'd0);
        chk("rst_rdata0", rdata0, 32'h0);
        chk("rst_rdy3", 32'(rdy3), 32'd1);
        chk("rst_resp3", 32'(resp3), 32'd0);
        chk("rst_rdata3", rdata3, 32'h0);

        // ---- zero-wait instance ----
        hsel0 = 1'b1;

        // Word write then read of 0x004.
        addr_ph(T_NSEQ, 1'b1, 32'h004, 3'd2);
        tick();
        chk("wr_data_rdy", 32'(rdy0), 32'd1);
        hwdata = 32'hDEADBEEF;
        addr_ph(T_NSEQ, 1'b0, 32'h004, 3'd2);
        tick();
        chk("rd004_data", rdata0, 32'hDEADBEEF);
        chk("rd004_resp", 32'(resp0), 32'd0);
        chk("rd004_rdy", 32'(rdy0), 32'd1);
        addr_ph(T_IDLE, 1'b0, 32'h0, 3'd2);
        tick();
        chk("idle_rdata", rdata0, 32'h0);

        // Byte lanes: word 0, byte 0xAB at 0x012, half 0x1234 at 0x010.
        addr_ph(T_NSEQ, 1'b1, 32'h010, 3'd2);
        tick();
        hwdata = 32'h0;
        addr_ph(T_NSEQ, 1'b1, 32'h012, 3'd0);
        tick();
        hwdata = 32'hFFABFFFF;
        addr_ph(T_NSEQ, 1'b1, 32'h010, 3'd1);
        tick();
        hwdata = 32'hFFFF1234;
        addr_ph(T_NSEQ, 1'b0, 32'h010, 3'd2);
        tick();
        chk("lanes_rd010", rdata0, 32'h00AB1234);

        // Known word at 0x000 and last word 0x3FC.
        addr_ph(T_NSEQ, 1'b1, 32'h000, 3'd2);
        tick();
        hwdata = 32'hCAFEF00D;
        addr_ph(T_NSEQ, 1'b1, 32'h3FC, 3'd2);
        tick();
        hwdata = 32'h600DF00D;
        addr_ph(T_NSEQ, 1'b0, 32'h3FC, 3'd2);
        tick();
        chk("rd3fc_top", rdata0, 32'h600DF00D);
        addr_ph(T_IDLE, 1'b0, 32'h0, 3'd2);
        tick();

        // Misaligned word read -> two-cycle ERROR.
        addr_ph(T_NSEQ, 1'b0, 32'h002, 3'd2);
        tick();
        chk("mis_err1_rdy", 32'(rdy0), 32'd0);
        chk("mis_err1_resp", 32'(resp0), 32'd1);
        addr_ph(T_IDLE, 1'b0, 32'h0, 3'd2);
        tick();
        chk("mis_err2_rdy", 32'(rdy0), 32'd1);
        chk("mis_err2_resp", 32'(resp0), 32'd1);
        tick();
        chk("mis_after_resp", 32'(resp0), 32'd0);

        // Out-of-range write to 0x400 must not hit the 0x000 alias.
        addr_ph(T_NSEQ, 1'b1, 32'h400, 3'd2);
        tick();
        chk("oor_err1_rdy", 32'(rdy0), 32'd0);
        chk("oor_err1_resp", 32'(resp0), 32'd1);
        hwdata = 32'hBADBAD00;
        addr_ph(T_IDLE, 1'b0, 32'h0, 3'd2);
        tick();
        chk("oor_err2_rdy", 32'(rdy0), 32'd1);
        chk("oor_err2_resp", 32'(resp0), 32'd1);
        tick();

        // HSIZE above word -> ERROR.
        addr_ph(T_NSEQ, 1'b0, 32'h008, 3'd3);
        tick();
        chk("sz3_err1_resp", 32'(resp0), 32'd1);
        addr_ph(T_IDLE, 1'b0, 32'h0, 3'd2);
        tick();
        tick();

        addr_ph(T_NSEQ, 1'b0, 32'h000, 3'd2);
        tick();
        chk("alias000", rdata0, 32'hCAFEF00D);

        // SEQ burst of four writes, then four reads.
        addr_ph(T_NSEQ, 1'b1, 32'h020, 3'd2);
        tick();
        for (int i = 1; i < 4; i++) begin
            hwdata = 32'(i);
            addr_ph(T_SEQ, 1'b1, 32'h020 + 32'(4 * i), 3'd2);
            tick();
        end
        hwdata = 32'd4;
        addr_ph(T_NSEQ, 1'b0, 32'h020, 3'd2);
        tick();
        chk("burst_rd0", rdata0, 32'd1);
        addr_ph(T_SEQ, 1'b0, 32'h024, 3'd2);
        tick();
        chk("burst_rd1", rdata0, 32'd2);
        addr_ph(T_SEQ, 1'b0, 32'h028, 3'd2);
        tick();
        chk("burst_rd2", rdata0, 32'd3);
        addr_ph(T_SEQ, 1'b0, 32'h02C, 3'd2);
        tick();
        chk("burst_rd3", rdata0, 32'd4);
        addr_ph(T_BUSY, 1'b0, 32'h030, 3'd2);
        tick();
        chk("busy_rdy", 32'(rdy0), 32'd1);
        chk("busy_resp", 32'(resp0), 32'd0);
        chk("busy_rdata", rdata0, 32'h0);

        // Write A immediately followed by read A.
        addr_ph(T_NSEQ, 1'b1, 32'h040, 3'd2);
        tick();
        hwdata = 32'h5A5A0001;
        addr_ph(T_NSEQ, 1'b0, 32'h040, 3'd2);
        tick();
        chk("raw_rd040", rdata0, 32'h5A5A0001);
        addr_ph(T_IDLE, 1'b0, 32'h0, 3'd2);
        tick();

        // ---- three-wait instance ----
        hsel0 = 1'b0;
        hsel3 = 1'b1;

        // Write 0x030 = 0x11111111; HWDATA is junk until the data cycle.
        addr_ph(T_NSEQ, 1'b1, 32'h030, 3'd2);
        tick();
        hwdata = 32'hFFFFFFFF;
        addr_ph(T_IDLE, 1'b0, 32'h0, 3'd2);
        chk("ws_w_rdy1", 32'(rdy3), 32'd0);
        tick();
        chk("ws_w_rdy2", 32'(rdy3), 32'd0);
        tick();
        chk("ws_w_rdy3", 32'(rdy3), 32'd0);
        tick();
        chk("ws_w_data_rdy", 32'(rdy3), 32'd1);
        hwdata = 32'h11111111;
        tick();
        chk("unsel_rdy0", 32'(rdy0), 32'd1);
        chk("unsel_rdata0", rdata0, 32'h0);

        // Single read with address phase held stable while stalled.
        addr_ph(T_NSEQ, 1'b0, 32'h030, 3'd2);
        tick();
        addr_ph(T_IDLE, 1'b0, 32'h030, 3'd2);
        for (int i = 0; i < 3; i++) begin
            chk("ws_r_rdy_low", 32'(rdy3), 32'd0);
            chk("ws_r_resp", 32'(resp3), 32'd0);
            tick();
        end
        chk("ws_r_rdy_high", 32'(rdy3), 32'd1);
        chk("ws_r_data", rdata3, 32'h11111111);
        tick();
        chk("ws_r_idle_rdy", 32'(rdy3), 32'd1);

        // ERROR gets no wait states.
        addr_ph(T_NSEQ, 1'b0, 32'h031, 3'd2);
        tick();
        chk("ws_err1_rdy", 32'(rdy3), 32'd0);
        chk("ws_err1_resp", 32'(resp3), 32'd1);
        addr_ph(T_IDLE, 1'b0, 32'h0, 3'd2);
        tick();
        chk("ws_err2_rdy", 32'(rdy3), 32'd1);
        chk("ws_err2_resp", 32'(resp3), 32'd1);
        tick();

        // Reset during the second WAIT cycle of a write to 0x030.
        addr_ph(T_NSEQ, 1'b1, 32'h030, 3'd2);
        tick();
        hwdata = 32'h22222222;
        addr_ph(T_IDLE, 1'b0, 32'h0, 3'd2);
        tick();
        chk("rst_mid_wait", 32'(rdy3), 32'd0);
        hreset = 1'b1;
        tick();
        hreset = 1'b0;
        chk("rst_mid_rdy", 32'(rdy3), 32'd1);
        chk("rst_mid_resp", 32'(resp3), 32'd0);
        chk("rst_mid_rdata", rdata3, 32'h0);
        tick();
        tick();
        tick();
        chk("rst_mid_stays", 32'(rdy3), 32'd1);

        addr_ph(T_NSEQ, 1'b0, 32'h030, 3'd2);
        tick();
        addr_ph(T_IDLE, 1'b0, 32'h0, 3'd2);
        tick();
        tick();
        tick();
        chk("rst_keep_rdy", 32'(rdy3), 32'd1);
        chk("rst_keep_data", rdata3, 32'h11111111);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
